// File: rtl/pipe_renderer_if.sv
// Pixel-stream bundle between the VGA timing stage and the pipe renderer.
// The master is the timing/game side; the slave is pipe_renderer.
interface pipe_renderer_if;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        run;
  logic        restart;
  logic        pipe_on;
  logic [11:0] pipe_rgb;
  logic        video_on_d;
  logic        score_tick;

  modport master (
    output p_tick, video_on, x, y, run, restart,
    input  pipe_on, pipe_rgb, video_on_d, score_tick
  );

  modport slave (
    input  p_tick, video_on, x, y, run, restart,
    output pipe_on, pipe_rgb, video_on_d, score_tick
  );
endinterface

// File: rtl/pipe_renderer.sv
// Scrolling obstacle pipes: a vblank update sequencer plus a one-pixel-latency renderer.
// Optional macro PIPE_SPEEDUP_EN raises the scroll step every 8 score ticks (max 4).
module pipe_renderer #(
  parameter int          NUM_PIPES   = 3,
  parameter int          PIPE_W      = 52,
  parameter int          GAP_H       = 120,
  parameter int          GAP_MIN     = 60,
  parameter int          SPACING     = 224,
  parameter int          SCROLL_STEP = 2,
  parameter int          CAP_H       = 8,
  parameter int          BIRD_X      = 160,
  parameter logic [11:0] BODY_RGB    = 12'h0A0,
  parameter logic [11:0] CAP_RGB     = 12'h060
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  pipe_renderer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [10:0] r_q       [NUM_PIPES];
  logic [10:0] r_d       [NUM_PIPES];
  logic [8:0]  gap_top_q [NUM_PIPES];
  logic [8:0]  gap_top_d [NUM_PIPES];
  logic [15:0] lfsr_q, lfsr_d;
  logic        score_q, score_d;
  logic        pipe_on_q, pipe_on_d;
  logic [11:0] pipe_rgb_q, pipe_rgb_d;
  logic        video_on_dq, video_on_dd;
  logic [2:0]  step;
  logic        frame_strobe;

`ifdef PIPE_SPEEDUP_EN
  logic [2:0] step_q, step_d;
  logic [2:0] score_cnt_q, score_cnt_d;
  assign step = step_q;
`else
  assign step = 3'(SCROLL_STEP);
`endif

  function automatic logic [10:0] home_pos(input int i);
    return 11'(640 + PIPE_W + i * SPACING);
  endfunction

  // Each pipe takes a different byte-window of the LFSR so a restart
  // gives every pipe its own gap; window 0 is the plain low byte.
  function automatic logic [8:0] draw_gap(input logic [15:0] l, input int i);
    logic [31:0] dbl;
    dbl = {l, l} >> (4 * i);
    return 9'(GAP_MIN) + {1'b0, dbl[7:0]};
  endfunction

  // Returns {covered, in_cap_band} for one pipe at the current pixel.
  function automatic logic [1:0] classify(input logic [9:0] px, input logic [9:0] py,
                                          input logic [10:0] r, input logic [8:0] gap);
    logic [11:0] xe, ye, re, ge;
    logic        in_col, out_gap, cap;
    xe      = {2'b00, px};
    ye      = {2'b00, py};
    re      = {1'b0, r};
    ge      = {3'b000, gap};
    in_col  = (xe + 12'(PIPE_W) >= re) && (xe < re);
    out_gap = (ye < ge) || (ye >= ge + 12'(GAP_H));
    cap     = (ye + 12'(CAP_H) >= ge) && (ye < ge + 12'(GAP_H + CAP_H));
    return {in_col && out_gap, cap};
  endfunction

  assign frame_strobe = bus.p_tick && (bus.x == 10'd639) && (bus.y == 10'd479);

  always_comb begin
    logic [10:0] old_r;
    logic [10:0] new_r;
    logic [1:0]  cls;
    logic        hit;
    logic [11:0] colour;

    state_d     = state_q;
    idx_d       = idx_q;
    r_d         = r_q;
    gap_top_d   = gap_top_q;
    score_d     = 1'b0;
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    pipe_on_d   = pipe_on_q;
    pipe_rgb_d  = pipe_rgb_q;
    video_on_dd = video_on_dq;
    old_r       = '0;
    new_r       = '0;
    cls         = '0;
    hit         = 1'b0;
    colour      = 12'h000;
`ifdef PIPE_SPEEDUP_EN
    step_d      = step_q;
    score_cnt_d = score_cnt_q;
`endif

    if (bus.restart) begin
      state_d = IDLE;
      idx_d   = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_d[i]       = home_pos(i);
        gap_top_d[i] = draw_gap(lfsr_q, i);
      end
`ifdef PIPE_SPEEDUP_EN
      step_d      = 3'(SCROLL_STEP);
      score_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_strobe && bus.run) begin
            state_d = UPDATE;
            idx_d   = '0;
          end
        end
        UPDATE: begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (idx_q == 2'(i)) begin
              old_r = r_q[i];
              if (old_r > {8'd0, step}) begin
                new_r = old_r - {8'd0, step};
              end else begin
                new_r        = old_r + 11'(NUM_PIPES * SPACING) - {8'd0, step};
                gap_top_d[i] = draw_gap(lfsr_q, 0);
              end
              r_d[i] = new_r;
              if ((old_r > 11'(BIRD_X)) && (new_r <= 11'(BIRD_X))) begin
                score_d = 1'b1;
              end
            end
          end
          if (idx_q == 2'(NUM_PIPES - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
`ifdef PIPE_SPEEDUP_EN
      if (score_d) begin
        score_cnt_d = score_cnt_q + 3'd1;
        if ((score_cnt_q == 3'd7) && (step_q < 3'd4)) begin
          step_d = step_q + 3'd1;
        end
      end
`endif
    end

    // Walk from the highest index down so the lowest covering pipe sets the colour.
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      cls = classify(bus.x, bus.y, r_q[i], gap_top_q[i]);
      if (bus.video_on && cls[1]) begin
        hit    = 1'b1;
        colour = cls[0] ? CAP_RGB : BODY_RGB;
      end
    end

    if (bus.p_tick) begin
      video_on_dd = bus.video_on;
      pipe_on_d   = hit;
      pipe_rgb_d  = colour;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lfsr_q      <= 16'hACE1;
      score_q     <= 1'b0;
      pipe_on_q   <= 1'b0;
      pipe_rgb_q  <= 12'h000;
      video_on_dq <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_q[i]       <= home_pos(i);
        gap_top_q[i] <= 9'(GAP_MIN + 64 * i);
      end
`ifdef PIPE_SPEEDUP_EN
      step_q      <= 3'(SCROLL_STEP);
      score_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      pipe_on_q   <= pipe_on_d;
      pipe_rgb_q  <= pipe_rgb_d;
      video_on_dq <= video_on_dd;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_q[i]       <= r_d[i];
        gap_top_q[i] <= gap_top_d[i];
      end
`ifdef PIPE_SPEEDUP_EN
      step_q      <= step_d;
      score_cnt_q <= score_cnt_d;
`endif
    end
  end

  assign bus.pipe_on    = pipe_on_q;
  assign bus.pipe_rgb   = pipe_rgb_q;
  assign bus.video_on_d = video_on_dq;
  assign bus.score_tick = score_q;

endmodule

// File: tb/tb_pipe_renderer.sv
// Directed scoreboard bench for pipe_renderer: frames are issued as single
// strobe pixels and rendering is probed pixel by pixel against a spec model.
module tb_pipe_renderer;

  localparam int          NP   = 3;
  localparam int          PW   = 52;
  localparam int          GH   = 120;
  localparam int          GM   = 60;
  localparam int          SP   = 224;
  localparam int          CH   = 8;
  localparam int          BX   = 160;
  localparam logic [11:0] BODY = 12'h0A0;
  localparam logic [11:0] CAP  = 12'h060;

  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;

  always #5 clk_100MHz = ~clk_100MHz;

  pipe_renderer_if bus ();

  pipe_renderer dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // Spec model of pipe state
  int          m_r   [NP];
  int          m_gap [NP];
  int          m_step;
  int          m_scores;
  logic [15:0] m_lfsr;

  typedef struct packed {
    logic        on;
    logic [11:0] rgb;
    logic        vod;
  } pix_t;

  pix_t pix_q[$];
  int   score_q[$];

  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  always @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsrNext(m_lfsr);
  end

  function automatic int gapDraw(input logic [15:0] l, input int i);
    logic [31:0] d;
    d = {l, l} >> (4 * i);
    return GM + int'(d[7:0]);
  endfunction

  task automatic modelReset(input logic [15:0] l, input bit from_restart);
    for (int i = 0; i < NP; i++) begin
      m_r[i]   = 640 + PW + i * SP;
      m_gap[i] = from_restart ? gapDraw(l, i) : GM + 64 * i;
    end
    m_step   = 2;
    m_scores = 0;
  endtask

  function automatic pix_t expPixel(input int px, input int py, input bit von);
    pix_t e;
    e.on  = 1'b0;
    e.rgb = 12'h000;
    e.vod = von;
    for (int i = NP - 1; i >= 0; i--) begin
      if (von && px >= m_r[i] - PW && px < m_r[i] &&
          (py < m_gap[i] || py >= m_gap[i] + GH)) begin
        e.on  = 1'b1;
        e.rgb = (py >= m_gap[i] - CH && py < m_gap[i] + GH + CH) ? CAP : BODY;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel tick; the registered result appears after the next edge.
  task automatic applyStimulus(input int px, input int py, input bit von);
    pix_t e;
    bus.p_tick   = 1'b1;
    bus.x        = 10'(px);
    bus.y        = 10'(py);
    bus.video_on = von;
    pix_q.push_back(expPixel(px, py, von));
    @(negedge clk_100MHz);
    bus.p_tick = 1'b0;
    e = pix_q.pop_front();
    checkOutput($sformatf("pipe_on(%0d,%0d)", px, py), 32'(bus.pipe_on), 32'(e.on));
    checkOutput($sformatf("pipe_rgb(%0d,%0d)", px, py), 32'(bus.pipe_rgb), 32'(e.rgb));
    checkOutput($sformatf("video_on_d(%0d,%0d)", px, py), 32'(bus.video_on_d), 32'(e.vod));
  endtask

  // Issue one end-of-frame strobe, advance the model, count score pulses.
  task automatic doFrame();
    logic [15:0] l;
    int          ticks;
    int          expected;
    int          old_r;
    int          new_r;
    bus.p_tick   = 1'b1;
    bus.x        = 10'd639;
    bus.y        = 10'd479;
    bus.video_on = 1'b0;
    @(negedge clk_100MHz);
    bus.p_tick = 1'b0;
    l = m_lfsr;
    expected = 0;
    if (bus.run) begin
      for (int i = 0; i < NP; i++) begin
        old_r = m_r[i];
        if (old_r > m_step) begin
          new_r = old_r - m_step;
        end else begin
          new_r    = old_r + NP * SP - m_step;
          m_gap[i] = GM + int'(l[7:0]);
        end
        m_r[i] = new_r;
        if (old_r > BX && new_r <= BX) begin
          expected++;
`ifdef PIPE_SPEEDUP_EN
          m_scores++;
          if ((m_scores % 8) == 0 && m_step < 4) m_step++;
`endif
        end
        l = lfsrNext(l);
      end
    end
    score_q.push_back(expected);
    ticks = 0;
    repeat (NP + 3) begin
      if (bus.score_tick === 1'b1) ticks++;
      @(negedge clk_100MHz);
    end
    checkOutput("score_ticks_per_frame", 32'(ticks), 32'(score_q.pop_front()));
  endtask

  initial begin
    logic [15:0] l;
    int          saved [NP];

    bus.p_tick   = 1'b0;
    bus.video_on = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.run      = 1'b0;
    bus.restart  = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk_100MHz);

    checkOutput("rst_pipe_on", 32'(bus.pipe_on), 32'd0);
    checkOutput("rst_pipe_rgb", 32'(bus.pipe_rgb), 32'd0);
    checkOutput("rst_video_on_d", 32'(bus.video_on_d), 32'd0);
    checkOutput("rst_score_tick", 32'(bus.score_tick), 32'd0);

    reset_n = 1'b1;
    modelReset(16'hACE1, 1'b0);
    checkOutput("rst_r0", 32'(dut.r_q[0]), 32'd692);
    checkOutput("rst_r2", 32'(dut.r_q[2]), 32'd1140);
    checkOutput("rst_gap1", 32'(dut.gap_top_q[1]), 32'd124);

    bus.run = 1'b1;
    doFrame();
    checkOutput("r0_after_frame0", 32'(dut.r_q[0]), 32'd690);

    // Everything is off-screen; video_on_d follows video_on one tick later
    applyStimulus(10, 10, 1'b1);
    applyStimulus(10, 11, 1'b0);
    applyStimulus(20, 20, 1'b1);
    @(negedge clk_100MHz);
    checkOutput("video_on_d_hold", 32'(bus.video_on_d), 32'd1);
    for (int px = 0; px < 640; px += 64) applyStimulus(px, 240, 1'b1);

    // Scroll pipe 0 to r=100; crossing at 160 is checked by the per-frame count
    for (int f = 0; f < 400 && m_r[0] != 100; f++) doFrame();
    checkOutput("r0_at_100", 32'(dut.r_q[0]), 32'd100);

    for (int px = 0; px < 640; px++) applyStimulus(px, 20, 1'b1);
    for (int px = 40; px < 110; px++) applyStimulus(px, 55, 1'b1);
    for (int px = 40; px < 110; px++) applyStimulus(px, 100, 1'b1);
    for (int px = 40; px < 110; px++) applyStimulus(px, 185, 1'b1);
    for (int px = 40; px < 110; px++) applyStimulus(px, 300, 1'b1);
    for (int px = 40; px < 110; px += 10) applyStimulus(px, 20, 1'b0);

    // Run on to the respawn of pipe 0 from r=2
    for (int f = 0; f < 100 && m_r[0] <= 600; f++) doFrame();
    checkOutput("r0_respawn", 32'(dut.r_q[0]), 32'd672);
    checkOutput("gap0_respawn", 32'(dut.gap_top_q[0]), 32'(m_gap[0]));
    for (int py = 0; py < 480; py++) applyStimulus(630, py, 1'b1);

    // Frozen for 10 frames
    bus.run = 1'b0;
    for (int i = 0; i < NP; i++) saved[i] = m_r[i];
    repeat (10) doFrame();
    for (int i = 0; i < NP; i++)
      checkOutput($sformatf("frozen_r%0d", i), 32'(dut.r_q[i]), 32'(saved[i]));
    for (int px = 0; px < 640; px += 7) applyStimulus(px, 20, 1'b1);

    // Restart while the sequencer is on pipe 1
    bus.run      = 1'b1;
    bus.p_tick   = 1'b1;
    bus.x        = 10'd639;
    bus.y        = 10'd479;
    bus.video_on = 1'b0;
    @(negedge clk_100MHz);
    bus.p_tick = 1'b0;
    @(negedge clk_100MHz);
    bus.restart = 1'b1;
    l = m_lfsr;
    @(negedge clk_100MHz);
    bus.restart = 1'b0;
    modelReset(l, 1'b1);
    checkOutput("restart_r0", 32'(dut.r_q[0]), 32'd692);
    checkOutput("restart_r1", 32'(dut.r_q[1]), 32'd916);
    checkOutput("restart_r2", 32'(dut.r_q[2]), 32'd1140);
    repeat (6) @(negedge clk_100MHz);
    checkOutput("restart_idle_r2", 32'(dut.r_q[2]), 32'd1140);
    for (int i = 0; i < NP; i++)
      checkOutput($sformatf("restart_gap%0d", i), 32'(dut.gap_top_q[i]), 32'(m_gap[i]));

    repeat (40) doFrame();
    checkOutput("r0_after_restart", 32'(dut.r_q[0]), 32'(m_r[0]));
    for (int py = 0; py < 480; py++) applyStimulus(600, py, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
